// File: rtl/itrx_amba4_axilite_slv.sv
// itrx_amba4_axilite_slv: AXI4-Lite slave bridging one port onto a single-outstanding register request bus.
module itrx_amba4_axilite_slv #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       NUM_REGS  = 16,
    parameter bit                PRIV_ONLY = 1'b0,
    parameter int unsigned       TIMEOUT   = 255,
    localparam int unsigned      STRB_W    = DATA_W / 8,
    localparam int unsigned      IDX_W     = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [2:0]        awprot,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [2:0]        arprot,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              reg_req,
    output logic              reg_wr,
    output logic [IDX_W-1:0]  reg_idx,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [STRB_W-1:0] reg_wstrb,
    input  logic              reg_ack,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_err
);
    localparam int unsigned       LSB      = $clog2(STRB_W);
    localparam logic [ADDR_W:0]   SPAN     = (ADDR_W+1)'(NUM_REGS * STRB_W);
    localparam logic [ADDR_W-1:0] ALIGN    = ~ADDR_W'(STRB_W - 1);
    localparam int unsigned       CNT_W    = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [1:0]        OKAY     = 2'b00;
    localparam logic [1:0]        SLVERR   = 2'b10;
    localparam logic [1:0]        DECERR   = 2'b11;

    typedef enum logic [2:0] {IDLE, WREQ, RREQ, WRESP, RRESP} state_t;

    state_t            state_q, state_d;
    logic              prefer_wr_q, prefer_wr_d;
    logic              aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic              aw_priv_q, aw_priv_d, ar_priv_q, ar_priv_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [1:0]        resp_q, resp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              aw_hs, w_hs, ar_hs, wr_elig, grant_wr, dec_err, priv_err, timed_out;
    logic [ADDR_W:0]   diff;
    logic              unused_ok;

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign arready   = arready_q;
    assign bvalid    = state_q == WRESP;
    assign rvalid    = state_q == RRESP;
    assign bresp     = bvalid ? resp_q : '0;
    assign rresp     = rvalid ? resp_q : '0;
    assign rdata     = rdata_q;
    assign reg_req   = (state_q == WREQ) || (state_q == RREQ);
    assign reg_wr    = wr_q;
    assign reg_idx   = idx_q;
    assign reg_wdata = wdata_q;
    assign reg_wstrb = wstrb_q;
    assign unused_ok = ^{awprot[2:1], arprot[2:1], diff[LSB-1:0]};

    // Ready flags are registered copies of !full so they stay low throughout reset.
    always_comb begin
        aw_hs     = awvalid & awready_q;
        w_hs      = wvalid & wready_q;
        ar_hs     = arvalid & arready_q;
        aw_full_d = (bvalid & bready) ? 1'b0 : aw_full_q | aw_hs;
        w_full_d  = (bvalid & bready) ? 1'b0 : w_full_q | w_hs;
        ar_full_d = (rvalid & rready) ? 1'b0 : ar_full_q | ar_hs;
        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        arready_d = !ar_full_d;
        aw_addr_d = aw_hs ? awaddr : aw_addr_q;
        aw_priv_d = aw_hs ? awprot[0] : aw_priv_q;
        w_data_d  = w_hs ? wdata : w_data_q;
        w_strb_d  = w_hs ? wstrb : w_strb_q;
        ar_addr_d = ar_hs ? araddr : ar_addr_q;
        ar_priv_d = ar_hs ? arprot[0] : ar_priv_q;
    end

    always_comb begin
        state_d     = state_q;
        prefer_wr_d = prefer_wr_q;
        resp_d      = resp_q;
        rdata_d     = rdata_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q + 1'b1;
        wr_elig     = aw_full_q & w_full_q;
        grant_wr    = wr_elig & (prefer_wr_q | !ar_full_q);
        // Borrow out of the subtraction lands above SPAN, so one compare covers both window edges.
        diff        = {1'b0, (grant_wr ? aw_addr_q : ar_addr_q) & ALIGN} - {1'b0, BASE_ADDR};
        dec_err     = diff >= SPAN;
        priv_err    = PRIV_ONLY & !(grant_wr ? aw_priv_q : ar_priv_q);
        timed_out   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
        case (state_q)
            IDLE: if (wr_elig | ar_full_q) begin
                prefer_wr_d = !grant_wr;
                wr_d        = grant_wr;
                idx_d       = IDX_W'(diff[ADDR_W-1:LSB]);
                wdata_d     = w_data_q;
                wstrb_d     = grant_wr ? w_strb_q : '0;
                rdata_d     = '0;
                cnt_d       = '0;
                resp_d      = dec_err ? DECERR : priv_err ? SLVERR : OKAY;
                state_d     = (dec_err | priv_err) ? (grant_wr ? WRESP : RRESP)
                                                   : (grant_wr ? WREQ : RREQ);
            end
            WREQ, RREQ: if (reg_ack | timed_out) begin
                resp_d  = (reg_ack & !reg_err) ? OKAY : SLVERR;
                rdata_d = (reg_ack & !reg_err & (state_q == RREQ)) ? reg_rdata : '0;
                state_d = state_q == WREQ ? WRESP : RRESP;
            end
            WRESP: state_d = bready ? IDLE : WRESP;
            RRESP: state_d = rready ? IDLE : RRESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            prefer_wr_q <= 1'b1;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            ar_full_q   <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            aw_addr_q   <= '0;
            aw_priv_q   <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            ar_addr_q   <= '0;
            ar_priv_q   <= 1'b0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prefer_wr_q <= prefer_wr_d;
            aw_full_q   <= aw_full_d;
            w_full_q    <= w_full_d;
            ar_full_q   <= ar_full_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            arready_q   <= arready_d;
            aw_addr_q   <= aw_addr_d;
            aw_priv_q   <= aw_priv_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            ar_addr_q   <= ar_addr_d;
            ar_priv_q   <= ar_priv_d;
            wr_q        <= wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_itrx_amba4_axilite_slv.sv
// tb_itrx_amba4_axilite_slv: directed scoreboard bench for the AXI4-Lite register slave.
module tb_itrx_amba4_axilite_slv;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
    localparam logic [1:0]  DECERR = 2'b11;

    logic        aclk, aresetn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata, reg_wdata, reg_rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb, reg_wstrb, reg_idx;
    logic [1:0]  bresp, rresp;
    logic        reg_req, reg_wr, reg_ack, reg_err;

    int          tests = 0, fails = 0;
    int          ack_dly = 1, rcnt = 0, last_len = 0, unstable = 0;
    bit          err_mode = 0;
    logic [40:0] first_req;
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [40:0] exp_req[$], got_req[$];

    itrx_amba4_axilite_slv #(
        .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .NUM_REGS(16), .PRIV_ONLY(1'b1), .TIMEOUT(4)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_req(reg_req), .reg_wr(reg_wr), .reg_idx(reg_idx), .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rd_model(input logic [3:0] i);
        return {16'hC0DE, 12'h000, i};
    endfunction

    // Register-side responder: logs each request, acks after ack_dly cycles (0 = never).
    initial begin
        reg_ack = 1'b0;
        reg_err = 1'b0;
        reg_rdata = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (reg_req) begin
                rcnt++;
                if (rcnt == 1) begin
                    first_req = {reg_wr, reg_idx, reg_wdata, reg_wstrb};
                    got_req.push_back(first_req);
                end else if ({reg_wr, reg_idx, reg_wdata, reg_wstrb} !== first_req) unstable++;
                reg_rdata = rd_model(reg_idx);
                reg_ack = (ack_dly != 0) && (rcnt == ack_dly);
                reg_err = reg_ack && err_mode;
            end else begin
                if (rcnt != 0) last_len = rcnt;
                rcnt = 0;
                reg_ack = 1'b0;
                reg_err = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input bit lw, input bit lr);
        int n = 0;
        bit ga, gw, gr;
        awvalid = lw;
        wvalid = lw;
        arvalid = lr;
        while ((awvalid || wvalid || arvalid) && n < 50) begin
            ga = awvalid && awready;
            gw = wvalid && wready;
            gr = arvalid && arready;
            @(negedge aclk);
            n++;
            if (ga) awvalid = 1'b0;
            if (gw) wvalid = 1'b0;
            if (gr) arvalid = 1'b0;
        end
        chk("launch", 64'({awvalid, wvalid, arvalid}), 64'(0));
    endtask

    task automatic write_op(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] eb, input bit er, input logic [3:0] ei);
        awaddr = a;
        awprot = p;
        wdata = d;
        wstrb = s;
        exp_b.push_back(eb);
        if (er) exp_req.push_back({1'b1, ei, d, s});
        launch(1'b1, 1'b0);
    endtask

    task automatic read_op(input logic [31:0] a, input logic [2:0] p, input bit er,
                           input logic [3:0] ei, input logic [1:0] rr, input logic [31:0] ed);
        araddr = a;
        arprot = p;
        exp_r.push_back({rr, ed});
        if (er) exp_req.push_back({1'b0, ei, 36'h0});
        launch(1'b0, 1'b1);
    endtask

    task automatic wait_b(input string tag);
        int n = 0;
        logic [1:0] e;
        while (!bvalid && n < 40) begin @(negedge aclk); n++; end
        chk({tag, "_bvalid"}, 64'(bvalid), 64'(1));
        e = exp_b.size() != 0 ? exp_b.pop_front() : 2'bxx;
        chk({tag, "_bresp"}, 64'(bresp), 64'(e));
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk({tag, "_bdone"}, 64'(bvalid), 64'(0));
    endtask

    task automatic wait_r(input string tag);
        int n = 0;
        logic [33:0] e;
        while (!rvalid && n < 40) begin @(negedge aclk); n++; end
        chk({tag, "_rvalid"}, 64'(rvalid), 64'(1));
        e = exp_r.size() != 0 ? exp_r.pop_front() : 34'hx;
        chk({tag, "_rresp_rdata"}, 64'({rresp, rdata}), 64'(e));
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        chk({tag, "_rdone"}, 64'(rvalid), 64'(0));
    endtask

    // Reads only define reg_wr and reg_idx, so the write payload is masked out for them.
    task automatic check_req(input string tag);
        logic [40:0] g, e;
        g = got_req.size() != 0 ? got_req.pop_front() : '1;
        e = exp_req.size() != 0 ? exp_req.pop_front() : '0;
        if (!e[40]) begin
            g[35:0] = '0;
            e[35:0] = '0;
        end
        chk(tag, 64'(g), 64'(e));
    endtask

    initial begin
        logic seen;
        aresetn = 1'b1;
        {awvalid, wvalid, arvalid, bready, rready} = '0;
        {awaddr, araddr, wdata} = '0;
        {awprot, arprot, wstrb} = '0;
        #2 aresetn = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        chk("rst_ready", 64'({awready, wready, arready}), 64'(0));
        chk("rst_valid", 64'({bvalid, rvalid, reg_req}), 64'(0));
        chk("rst_resp", 64'({bresp, rresp, rdata}), 64'(0));
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_ready", 64'({awready, wready, arready}), 64'(3'b111));

        ack_dly = 3;
        write_op(BASE + 32'h8, 3'b001, 32'hA5A5_0001, 4'hF, OKAY, 1'b1, 4'd2);
        chk("w1_lat0", 64'(reg_req), 64'(0));
        @(negedge aclk);
        chk("w1_lat1", 64'(reg_req), 64'(1));
        wait_b("w1");
        chk("w1_len", 64'(last_len), 64'(3));
        check_req("w1_req");

        read_op(BASE + 32'h40, 3'b001, 1'b0, 4'd0, DECERR, 32'h0);
        chk("r_dec_lat0", 64'(rvalid), 64'(0));
        @(negedge aclk);
        chk("r_dec_lat1", 64'(rvalid), 64'(1));
        wait_r("r_dec");
        write_op(BASE - 32'h4, 3'b001, 32'h1234_5678, 4'hF, DECERR, 1'b0, 4'd0);
        wait_b("w_dec");
        chk("dec_noreq", 64'(got_req.size()), 64'(0));

        read_op(BASE + 32'h4, 3'b000, 1'b0, 4'd0, SLVERR, 32'h0);
        @(negedge aclk);
        chk("r_priv_lat1", 64'(rvalid), 64'(1));
        wait_r("r_priv");
        write_op(BASE + 32'h4, 3'b010, 32'h5555_AAAA, 4'hF, SLVERR, 1'b0, 4'd0);
        wait_b("w_priv");
        chk("priv_noreq", 64'(got_req.size()), 64'(0));
        ack_dly = 2;
        read_op(BASE + 32'h4, 3'b001, 1'b1, 4'd1, OKAY, rd_model(4'd1));
        wait_r("r_ok");
        chk("r_ok_len", 64'(last_len), 64'(2));
        check_req("r_ok_req");

        ack_dly = 1;
        awaddr = BASE + 32'h14; awprot = 3'b001; wdata = 32'h1111_2222; wstrb = 4'hF;
        araddr = BASE + 32'h18; arprot = 3'b001;
        exp_b.push_back(OKAY);
        exp_r.push_back({OKAY, rd_model(4'd6)});
        exp_req.push_back({1'b1, 4'd5, 32'h1111_2222, 4'hF});
        exp_req.push_back({1'b0, 4'd6, 36'h0});
        launch(1'b1, 1'b1);
        wait_b("g_w0");
        wait_r("g_r0");
        awaddr = BASE + 32'h1C; wdata = 32'h3333_4444; wstrb = 4'h3;
        araddr = BASE + 32'h3F;
        exp_b.push_back(OKAY);
        exp_r.push_back({OKAY, rd_model(4'd15)});
        exp_req.push_back({1'b1, 4'd7, 32'h3333_4444, 4'h3});
        exp_req.push_back({1'b0, 4'd15, 36'h0});
        launch(1'b1, 1'b1);
        wait_b("g_w1");
        wait_r("g_r1");
        check_req("g_req_w0");
        check_req("g_req_r0");
        check_req("g_req_w1");
        check_req("g_req_r1");

        ack_dly = 0;
        write_op(BASE + 32'hC, 3'b001, 32'hDEAD_BEEF, 4'hF, SLVERR, 1'b1, 4'd3);
        wait_b("w_to");
        chk("w_to_len", 64'(last_len), 64'(4));
        check_req("w_to_req");

        ack_dly = 1;
        err_mode = 1'b1;
        read_op(BASE + 32'h20, 3'b001, 1'b1, 4'd8, SLVERR, 32'h0);
        wait_r("r_err");
        check_req("r_err_req");
        err_mode = 1'b0;

        write_op(BASE + 32'h10, 3'b001, 32'h0BAD_F00D, 4'h0, OKAY, 1'b1, 4'd4);
        wait_b("w_nostrb");
        check_req("w_nostrb_req");

        ack_dly = 0;
        awaddr = BASE + 32'h24; awprot = 3'b001; wdata = 32'hCAFE_0009; wstrb = 4'hF;
        exp_req.push_back({1'b1, 4'd9, 32'hCAFE_0009, 4'hF});
        launch(1'b1, 1'b0);
        @(negedge aclk);
        chk("rst_mid_req_on", 64'(reg_req), 64'(1));
        check_req("rst_mid_req");
        #1 aresetn = 1'b0;
        #1 chk("rst_mid_req_drop", 64'(reg_req), 64'(0));
        chk("rst_mid_ready", 64'({awready, wready, arready}), 64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_mid_awready", 64'(awready), 64'(1));
        seen = 1'b0;
        repeat (8) begin
            seen = seen | bvalid | rvalid | reg_req;
            @(negedge aclk);
        end
        chk("rst_mid_quiet", 64'(seen), 64'(0));
        ack_dly = 1;
        read_op(BASE + 32'h8, 3'b001, 1'b1, 4'd2, OKAY, rd_model(4'd2));
        wait_r("r_recover");
        check_req("r_recover_req");

        chk("req_stable", 64'(unstable), 64'(0));
        chk("sb_empty", 64'(exp_b.size() + exp_r.size() + exp_req.size() + got_req.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
